// File: rtl/lfsr_pkg.sv
// Shared types and tap masks for the lfsr_gen block: FSM state encoding and
// maximal-length feedback masks for common widths.
package lfsr_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } lfsr_state_e;

  localparam logic [6:0]  TAPS_7  = 7'h44;
  localparam logic [7:0]  TAPS_8  = 8'hB8;
  localparam logic [15:0] TAPS_16 = 16'hB400;

endpackage : lfsr_pkg

// File: rtl/lfsr_period_cnt.sv
// Period measurement: counts steps from a captured reference state until the state recurs.
// Latency: period_o/period_vld_o update on the edge of the returning step; no backpressure.
module lfsr_period_cnt #(
  parameter int unsigned      WIDTH = 7,
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             step_i,
  input  logic [WIDTH-1:0] step_val_i,
  output logic [WIDTH:0]   period_o,
  output logic             period_vld_o
);

  logic [WIDTH-1:0] ref_q, ref_d;
  logic [WIDTH:0]   cnt_q, cnt_d;
  logic [WIDTH:0]   period_q, period_d;
  logic             vld_q, vld_d;

  always_comb begin
    ref_d    = ref_q;
    cnt_d    = cnt_q;
    period_d = period_q;
    vld_d    = vld_q;
    if (load_i) begin
      ref_d    = load_val_i;
      cnt_d    = '0;
      period_d = '0;
      vld_d    = 1'b0;
    end else if (step_i) begin
      // Returning to the reference closes one full cycle of the sequence.
      if (step_val_i == ref_q) begin
        period_d = cnt_q + 1'b1;
        vld_d    = 1'b1;
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ref_q    <= SEED;
      cnt_q    <= '0;
      period_q <= '0;
      vld_q    <= 1'b0;
    end else begin
      ref_q    <= ref_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      vld_q    <= vld_d;
    end
  end

  assign period_o     = period_q;
  assign period_vld_o = vld_q;

endmodule : lfsr_period_cnt

// File: rtl/lfsr_gen.sv
// Fibonacci LFSR with free-run, load and counted-burst stepping; one step per edge, no backpressure.
// Optional period counter built only when LFSR_GEN_PERIOD_EN is defined.
module lfsr_gen
  import lfsr_pkg::*;
#(
  parameter int unsigned      WIDTH = 7,
  parameter logic [WIDTH-1:0] TAPS  = TAPS_7,
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(1),
  parameter int unsigned      CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             step_req,
  input  logic [CNT_W-1:0] step_cnt,
  output logic             step_busy,
  output logic             step_done,
  output logic [WIDTH-1:0] data_out,
  output logic             lockup,
  output logic [WIDTH:0]   period_out,
  output logic             period_valid
);

  if (SEED == '0) begin : g_seed_chk
    $error("lfsr_gen: SEED must be non-zero");
  end
  if (WIDTH < 3 || WIDTH > 32) begin : g_width_chk
    $error("lfsr_gen: WIDTH must be in 3..32");
  end

  function automatic logic [WIDTH-1:0] lfsr_next(input logic [WIDTH-1:0] s);
    return {s[WIDTH-2:0], ^(s & TAPS)};
  endfunction

  lfsr_state_e      fsm_q, fsm_d;
  logic [WIDTH-1:0] state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             done_q, done_d;
  logic             lock_q, lock_d;
  logic [WIDTH-1:0] step_val;

  assign step_val = lfsr_next(state_q);

  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    count_d = count_q;
    done_d  = 1'b0;
    lock_d  = lock_q;
    if (load) begin
      // A zero load would freeze the register, so recover to SEED and flag it.
      state_d = (load_val == '0) ? SEED : load_val;
      lock_d  = (load_val == '0);
      fsm_d   = IDLE;
    end else begin
      case (fsm_q)
        RUN: begin
          state_d = step_val;
          count_d = count_q - 1'b1;
          if (count_q == CNT_W'(1)) begin
            fsm_d  = IDLE;
            done_d = 1'b1;
          end
        end
        default: begin
          if (step_req) begin
            count_d = step_cnt;
            if (step_cnt == '0) begin
              done_d = 1'b1;
            end else begin
              fsm_d = RUN;
            end
          end else if (en) begin
            state_d = step_val;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q   <= IDLE;
      state_q <= SEED;
      count_q <= '0;
      done_q  <= 1'b0;
      lock_q  <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      count_q <= count_d;
      done_q  <= done_d;
      lock_q  <= lock_d;
    end
  end

  assign step_busy = (fsm_q == RUN);
  assign step_done = done_q;
  assign data_out  = state_q;
  assign lockup    = lock_q;

`ifdef LFSR_GEN_PERIOD_EN
  logic step_taken;

  assign step_taken = !load && ((fsm_q == RUN) || (!step_req && en));

  lfsr_period_cnt #(
    .WIDTH (WIDTH),
    .SEED  (SEED)
  ) u_period (
    .clk_i        (clk),
    .rst_i        (rst),
    .load_i       (load),
    .load_val_i   (state_d),
    .step_i       (step_taken),
    .step_val_i   (step_val),
    .period_o     (period_out),
    .period_vld_o (period_valid)
  );
`else
  assign period_out   = '0;
  assign period_valid = 1'b0;
`endif

endmodule : lfsr_gen
